// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encodings and default geometry.
package icache_pkg;

   typedef enum logic {
      ICACHE_IDLE   = 1'b0,
      ICACHE_REFILL = 1'b1
   } icache_state_e;

   localparam int ICACHE_LINES = 16;
   localparam int ICACHE_WORDS = 4;

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: LINES x WORDS x 32, one synchronous write port and one
// asynchronous read port so hits return in the lookup cycle.
module icache_data_ram
   import icache_pkg::*;
#(
   parameter  int LINES = ICACHE_LINES,
   parameter  int WORDS = ICACHE_WORDS,
   localparam int IB    = $clog2(LINES),
   localparam int OB    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [IB-1:0] i_wline,
   input  logic [OB-1:0] i_wword,
   input  logic [31:0]   i_wdata,
   input  logic [IB-1:0] i_rline,
   input  logic [OB-1:0] i_rword,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [LINES][WORDS];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wline][i_wword] <= i_wdata;
   end

   assign o_rdata = r_mem[i_rline][i_rword];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, stall
// plus word-by-word line refill on a miss, global invalidate via flush.
module icache
   import icache_pkg::*;
#(
   parameter int LINES = ICACHE_LINES,
   parameter int WORDS = ICACHE_WORDS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   output logic [31:0] i_data,
   output logic        i_stall,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int LW = 30 - OB;   // {tag,index} width
   localparam int TB = LW - IB;

   logic [29:0]   w_waddr;
   logic [OB-1:0] w_off;
   logic [LW-1:0] w_line;
   logic [IB-1:0] w_index;
   logic [TB-1:0] w_tag;

   assign w_waddr = 30'(i_addr >> 2);
   assign w_off   = w_waddr[OB-1:0];
   assign w_line  = w_waddr[29:OB];
   assign w_index = w_line[IB-1:0];
   assign w_tag   = w_line[LW-1:IB];

   icache_state_e r_state, w_state_nxt;
   logic [LINES-1:0] r_valid;
   logic [TB-1:0]    r_tag [LINES];
   logic [LW-1:0]    r_rf_line, w_line_nxt;
   logic [OB-1:0]    r_rf_cnt, w_cnt_nxt, w_cnt_inc;
   logic             r_flush_pend, w_pend_nxt;
   logic             r_mem_req, w_req_nxt;
   logic [31:0]      r_mem_addr, w_addr_nxt;
   logic             w_hit, w_we, w_fill_done, w_last;
   logic [IB-1:0]    w_rf_index;
   logic [TB-1:0]    w_rf_tag;

   assign w_rf_index = r_rf_line[IB-1:0];
   assign w_rf_tag   = r_rf_line[LW-1:IB];
   assign w_cnt_inc  = r_rf_cnt + OB'(1);
   assign w_last     = (r_rf_cnt == OB'(WORDS - 1));

   assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag) && (r_state == ICACHE_IDLE);
   assign i_stall  = ~w_hit;
   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;

   always_comb begin
      w_state_nxt = r_state;
      w_line_nxt  = r_rf_line;
      w_cnt_nxt   = r_rf_cnt;
      w_pend_nxt  = r_flush_pend;
      w_req_nxt   = r_mem_req;
      w_addr_nxt  = r_mem_addr;
      w_we        = 1'b0;
      w_fill_done = 1'b0;
      case (r_state)
         ICACHE_IDLE: begin
            if (!w_hit) begin
               w_line_nxt  = w_line;
               w_cnt_nxt   = '0;
               w_req_nxt   = 1'b1;
               w_addr_nxt  = {w_line, {OB{1'b0}}, 2'b00};
               w_state_nxt = ICACHE_REFILL;
            end
         end
         ICACHE_REFILL: begin
            if (flush) w_pend_nxt = 1'b1;
            if (mem_ack) begin
               w_we      = 1'b1;
               w_cnt_nxt = w_cnt_inc;
               if (!w_last) begin
                  w_addr_nxt = {r_rf_line, w_cnt_inc, 2'b00};
               end else begin
                  w_req_nxt   = 1'b0;
                  w_fill_done = 1'b1;
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = ICACHE_IDLE;
               end
            end
         end
         default: w_state_nxt = ICACHE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ICACHE_IDLE;
         r_valid      <= '0;
         r_rf_line    <= '0;
         r_rf_cnt     <= '0;
         r_flush_pend <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_rf_line    <= w_line_nxt;
         r_rf_cnt     <= w_cnt_nxt;
         r_flush_pend <= w_pend_nxt;
         r_mem_req    <= w_req_nxt;
         r_mem_addr   <= w_addr_nxt;
         if (flush) r_valid <= '0;
         // A flush seen anywhere during the refill leaves the new line invalid.
         if (w_fill_done) r_valid[w_rf_index] <= ~(r_flush_pend | flush);
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_done) r_tag[w_rf_index] <= w_rf_tag;
   end

   icache_data_ram #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) u_data (
      .clk     (clk),
      .i_we    (w_we),
      .i_wline (w_rf_index),
      .i_wword (r_rf_cnt),
      .i_wdata (mem_rdata),
      .i_rline (w_index),
      .i_rword (w_off),
      .o_rdata (i_data)
   );

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (LINES=16, WORDS=4) with a
// backing-memory responder returning 0xA0 + word address.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_addr = '0;
   logic [31:0] i_data;
   logic        i_stall;
   logic        flush = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int fails  = 0;
   int mode   = 0;   // 0: zero-wait, 1: ack every third request cycle
   int wcnt   = 0;
   logic [31:0] acked [$];

   icache #(.LINES(16), .WORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_addr    (i_addr),
      .i_data    (i_data),
      .i_stall   (i_stall),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return 32'hA0 + (a >> 2);
   endfunction

   always @(negedge clk) begin
      logic ack;
      if (!mem_req) wcnt = 0;
      else          wcnt = wcnt + 1;
      ack = (mode == 0) ? mem_req : (mem_req && wcnt == 3);
      if (ack) begin
         wcnt = 0;
         acked.push_back(mem_addr);
      end
      mem_ack   = ack;
      mem_rdata = exp_word(mem_addr);
   end

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   // Stall cycles counted from the current (stalled) cycle; -1 on timeout.
   task automatic wait_unstall(output int n);
      n = 1;
      repeat (100) begin
         next_cycle();
         if (!i_stall) return;
         n++;
      end
      n = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_addr = 32'h0;
      repeat (2) next_cycle();
      checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL reset_stall got=%b exp=1", i_stall); end
      rst = 1'b0;
      #1;
   endtask

   task automatic test_cold_miss();
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL cold_c0_stall got=%b exp=1", i_stall); end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 32'((k - 1) * 4) || i_stall !== 1'b1) begin
            fails++;
            $display("FAIL cold_c%0d req=%b addr=%h stall=%b exp req=1 addr=%h stall=1",
                     k, mem_req, mem_addr, i_stall, 32'((k - 1) * 4));
         end
      end
      next_cycle();
      checks++; if (i_stall !== 1'b0) begin fails++; $display("FAIL cold_c5_stall got=%b exp=0", i_stall); end
      checks++; if (i_data !== 32'hA0) begin fails++; $display("FAIL cold_c5_data got=%h exp=a0", i_data); end
      i_addr = 32'h8;
      #1;
      checks++;
      if (i_stall !== 1'b0 || i_data !== 32'hA2) begin
         fails++; $display("FAIL cold_hit8 stall=%b data=%h exp stall=0 data=a2", i_stall, i_data);
      end
   endtask

   task automatic test_conflict();
      int n;
      next_cycle();
      acked.delete();
      i_addr = 32'h100;
      #1;
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL conflict_miss got=%b exp=1", i_stall); end
      wait_unstall(n);
      checks++; if (n != 5) begin fails++; $display("FAIL conflict_stall got=%0d exp=5", n); end
      checks++; if (acked.size() != 4) begin fails++; $display("FAIL conflict_nacks got=%0d exp=4", acked.size()); end
      for (int i = 0; i < 4 && i < acked.size(); i++) begin
         checks++;
         if (acked[i] !== 32'h100 + 32'(4 * i)) begin
            fails++; $display("FAIL conflict_addr%0d got=%h exp=%h", i, acked[i], 32'h100 + 32'(4 * i));
         end
      end
      checks++; if (i_data !== 32'hE0) begin fails++; $display("FAIL conflict_data got=%h exp=e0", i_data); end
      next_cycle();
      i_addr = 32'h0;
      #1;
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL conflict_remiss got=%b exp=1", i_stall); end
      wait_unstall(n);
      checks++; if (n != 5) begin fails++; $display("FAIL conflict_restore got=%0d exp=5", n); end
   endtask

   task automatic test_supervisor();
      int n;
      next_cycle();
      acked.delete();
      i_addr = 32'h8000_0000;
      #1;
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL super_miss got=%b exp=1", i_stall); end
      wait_unstall(n);
      checks++; if (n != 5) begin fails++; $display("FAIL super_stall got=%0d exp=5", n); end
      checks++;
      if (acked.size() < 1 || acked[0] !== 32'h8000_0000) begin
         fails++; $display("FAIL super_addr got=%h exp=80000000", acked.size() > 0 ? acked[0] : 32'hx);
      end
      checks++; if (i_data !== 32'h2000_00A0) begin fails++; $display("FAIL super_data got=%h exp=200000a0", i_data); end
   endtask

   task automatic test_wait_states();
      int n, bad;
      logic prev_wait;
      logic [31:0] prev_addr;
      mode = 1;
      next_cycle();
      acked.delete();
      i_addr = 32'h40;
      #1;
      n = 0; bad = 0; prev_wait = 1'b0; prev_addr = '0;
      for (int c = 0; c < 60; c++) begin
         if (!i_stall) break;
         n++;
         if (prev_wait && (mem_req !== 1'b1 || mem_addr !== prev_addr)) bad++;
         prev_wait = mem_req && !mem_ack;
         prev_addr = mem_addr;
         next_cycle();
      end
      checks++; if (n != 13) begin fails++; $display("FAIL wait_stall got=%0d exp=13", n); end
      checks++; if (bad != 0) begin fails++; $display("FAIL wait_stable got=%0d changes exp=0", bad); end
      checks++; if (acked.size() != 4) begin fails++; $display("FAIL wait_nacks got=%0d exp=4", acked.size()); end
      checks++; if (i_data !== 32'hB0) begin fails++; $display("FAIL wait_data got=%h exp=b0", i_data); end
      mode = 0;
   endtask

   task automatic test_flush_refill();
      int n;
      next_cycle();
      acked.delete();
      i_addr = 32'h0;
      #1;
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL fref_miss got=%b exp=1", i_stall); end
      next_cycle();
      next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      wait_unstall(n);
      checks++; if (n != 7) begin fails++; $display("FAIL fref_stall got=%0d exp=7", n); end
      checks++; if (acked.size() != 8) begin fails++; $display("FAIL fref_nacks got=%0d exp=8", acked.size()); end
      for (int i = 0; i < 8 && i < acked.size(); i++) begin
         checks++;
         if (acked[i] !== 32'(4 * (i % 4))) begin
            fails++; $display("FAIL fref_addr%0d got=%h exp=%h", i, acked[i], 32'(4 * (i % 4)));
         end
      end
      checks++; if (i_data !== 32'hA0) begin fails++; $display("FAIL fref_data got=%h exp=a0", i_data); end
      next_cycle();
      i_addr = 32'h40;
      #1;
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL fref_other_inval got=%b exp=1", i_stall); end
      wait_unstall(n);
      checks++; if (n != 5) begin fails++; $display("FAIL fref_other_refill got=%0d exp=5", n); end
   endtask

   task automatic test_flush_idle();
      int n;
      next_cycle();
      checks++; if (i_stall !== 1'b0) begin fails++; $display("FAIL fidle_prehit got=%b exp=0", i_stall); end
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      #1;
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL fidle_stall got=%b exp=1", i_stall); end
      wait_unstall(n);
      checks++; if (n != 5) begin fails++; $display("FAIL fidle_refill got=%0d exp=5", n); end
   endtask

   task automatic test_reset_mid();
      int n;
      next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      i_addr = 32'h0;
      #1;
      next_cycle();
      checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rmid_req_c1 got=%b exp=1", mem_req); end
      next_cycle();
      rst = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmid_req_drop got=%b exp=0", mem_req); end
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL rmid_stall got=%b exp=1", i_stall); end
      next_cycle();
      next_cycle();
      rst = 1'b0;
      acked.delete();
      #1;
      checks++; if (i_stall !== 1'b1) begin fails++; $display("FAIL rmid_post_miss got=%b exp=1", i_stall); end
      wait_unstall(n);
      checks++; if (n != 5) begin fails++; $display("FAIL rmid_refill got=%0d exp=5", n); end
      checks++; if (acked.size() != 4) begin fails++; $display("FAIL rmid_nacks got=%0d exp=4", acked.size()); end
      for (int i = 0; i < 4 && i < acked.size(); i++) begin
         checks++;
         if (acked[i] !== 32'(4 * i)) begin
            fails++; $display("FAIL rmid_addr%0d got=%h exp=%h", i, acked[i], 32'(4 * i));
         end
      end
      checks++; if (i_data !== 32'hA0) begin fails++; $display("FAIL rmid_data got=%h exp=a0", i_data); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_conflict();
      test_supervisor();
      test_wait_states();
      test_flush_refill();
      test_flush_idle();
      test_reset_mid();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
